// File: rtl/riscv_isa_pkg.sv
// Shared RV64I encoding constants, the descriptor kind enum and the loader FSM state type.
// Used by the encoder/loader and by the Control opcode decoder.
package riscv_isa_pkg;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_SD  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;

  localparam logic [2:0] F3_DWORD = 3'b011;
  localparam logic [2:0] F3_BEQ   = 3'b000;

  typedef enum logic [2:0] {
    K_R   = 3'd0,
    K_IMM = 3'd1,
    K_LD  = 3'd2,
    K_SD  = 3'd3,
    K_BEQ = 3'd4,
    K_END = 3'd7
  } kind_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_e;

  // A 13-bit immediate fits in 12 signed bits when its top two bits agree.
  function automatic logic imm12_fits(input logic [12:0] imm);
    return imm[12] == imm[11];
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: descriptor fields -> 32-bit RV64I word, reject and END flags.
// Ports: kind/funct3/funct7/rd/rs1/rs2/imm in; word_o, reject_o, end_o out.
module instr_pack
  import riscv_isa_pkg::*;
(
  input  logic [2:0]  kind_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [12:0] imm_i,
  output logic [31:0] word_o,
  output logic        reject_o,
  output logic        end_o
);

  always_comb begin
    word_o   = '0;
    reject_o = 1'b0;
    end_o    = 1'b0;
    unique case (1'b1)
      kind_i == K_R: begin
        word_o = {funct7_i, rs2_i, rs1_i,
                  funct3_i, rd_i, OPC_R};
      end
      kind_i == K_IMM: begin
        word_o   = {imm_i[11:0], rs1_i,
                    funct3_i, rd_i, OPC_IMM};
        reject_o = !imm12_fits(imm_i);
      end
      kind_i == K_LD: begin
        word_o   = {imm_i[11:0], rs1_i,
                    F3_DWORD, rd_i, OPC_LD};
        reject_o = !imm12_fits(imm_i);
      end
      kind_i == K_SD: begin
        word_o   = {imm_i[11:5], rs2_i, rs1_i,
                    F3_DWORD, imm_i[4:0], OPC_SD};
        reject_o = !imm12_fits(imm_i);
      end
      kind_i == K_BEQ: begin
        word_o   = {imm_i[12], imm_i[10:5],
                    rs2_i, rs1_i, F3_BEQ,
                    imm_i[4:1], imm_i[11],
                    OPC_BEQ};
        // Branch offsets must be halfword aligned.
        reject_o = imm_i[0];
      end
      kind_i == K_END: begin
        end_o = 1'b1;
      end
      default: begin
        reject_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Packs symbolic descriptors into RV64I words and streams them into IMEM.
// Ports: start, valid/ready descriptor in; imem_we/addr/wdata out; word_count, busy, done, err.
module instr_encoder_loader
  import riscv_isa_pkg::*;
#(
  parameter int IMEM_AW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_kind,
  input  logic [2:0]         in_funct3,
  input  logic [6:0]         in_funct7,
  input  logic [4:0]         in_rd,
  input  logic [4:0]         in_rs1,
  input  logic [4:0]         in_rs2,
  input  logic [12:0]        in_imm,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic [IMEM_AW:0]   word_count,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int DEPTH = 2 ** IMEM_AW;
  localparam logic [IMEM_AW:0] DEPTH_W =
    (IMEM_AW + 1)'(DEPTH);
  localparam logic [IMEM_AW:0] LAST_W =
    (IMEM_AW + 1)'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [IMEM_AW:0]    ptr_q, ptr_d;
  logic [IMEM_AW:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [IMEM_AW-1:0]  addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                err_q, err_d;

  logic [31:0] word;
  logic        reject;
  logic        is_end;
  logic        accept;

  instr_pack u_pack (
    .kind_i   (in_kind),
    .funct3_i (in_funct3),
    .funct7_i (in_funct7),
    .rd_i     (in_rd),
    .rs1_i    (in_rs1),
    .rs2_i    (in_rs2),
    .imm_i    (in_imm),
    .word_o   (word),
    .reject_o (reject),
    .end_o    (is_end)
  );

  // ptr_q always equals word_count plus the pending write,
  // so it doubles as the occupancy seen by in_ready.
  assign in_ready = (state_q == S_LOAD) && (ptr_q < DEPTH_W);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;

    // The write issued this cycle retires at the coming edge.
    if (we_q) begin
      cnt_d = cnt_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (reject) begin
            err_d = 1'b1;
          end else if (is_end) begin
            state_d = S_DONE;
          end else begin
            we_d    = 1'b1;
            addr_d  = ptr_q[IMEM_AW-1:0];
            wdata_d = word;
            ptr_d   = ptr_q + 1'b1;
            if (ptr_q == LAST_W) begin
              state_d = S_DONE;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign word_count = cnt_q;
  assign busy       = (state_q == S_LOAD);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

- Encoder counterpart to the `Control` opcode decoder.
- Accepts symbolic instruction descriptors (kind, register fields, immediate) over a valid/ready handshake and packs them into 32-bit RV64I words for the five opcodes the control decoder recognises.
- Writes the words sequentially into instruction memory through a single-cycle write port.
- Sits between the test/boot loader front end and the IMEM write port of the pipeline.

## Interface

Parameters:
- IMEM_AW, 8, IMEM word-address width; capacity DEPTH = 2**IMEM_AW words

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: begin or restart a load session
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted when in_valid & in_ready
- in_kind  in  3  0=R, 1=IMM, 2=LD, 3=SD, 4=BEQ, 7=END; 5, 6 illegal
- in_funct3  in  3  used by R and IMM only
- in_funct7  in  7  used by R only
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  13  signed immediate, byte offset for BEQ
- imem_we  out  1  one-cycle write strobe
- imem_addr  out  IMEM_AW  word address
- imem_wdata  out  32  encoded instruction
- word_count  out  IMEM_AW+1  words written this session
- busy  out  1  state == LOAD
- done  out  1  state == DONE
- err  out  1  sticky: at least one descriptor rejected this session

## Operation

States and transitions:
- IDLE: wait for start.
- LOAD: in_ready = (word_count + pend < DEPTH), where pend = imem_we.
- DONE: hold until start.
- Transitions: IDLE -start-> LOAD; LOAD -accepted END, or accept filling the last slot-> DONE; DONE -start-> LOAD. start in LOAD is ignored.

On entry to LOAD:
- word_count and write pointer clear to 0; err clears.

Encoding, for each accepted descriptor:
- R: {funct7, rs2, rs1, funct3, rd, 0110011}
- IMM: {imm[11:0], rs1, funct3, rd, 0010011}
- LD: {imm[11:0], rs1, 011, rd, 0000011}
- SD: {imm[11:5], rs2, rs1, 011, imm[4:0], 0100011}
- BEQ: {imm[12], imm[10:5], rs2, rs1, 000, imm[4:1], imm[11], 1100011}

Rejection:
- Causes: illegal kind; IMM/LD/SD with imm[12] != imm[11] (out of 12-bit range); BEQ with imm[0] = 1.
- Effect: descriptor is consumed, nothing is written, err is set, pointer does not advance.

END:
- Consumed, never written.

## Timing

- Reset: state IDLE; in_ready, imem_we, busy, done, err = 0; imem_addr, imem_wdata, word_count = 0.
- Latency: accept at edge N produces imem_we = 1 during cycle N+1, with imem_addr = pointer before increment and imem_wdata = encoded word. word_count increments at edge N+1.
- Throughput: one descriptor per cycle, back-to-back.
- imem_addr and imem_wdata are registered and hold their last values when imem_we = 0.
- Full:
  - The accept taking the last free slot moves the state to DONE at that same edge.
  - Its write still issues in the following cycle.
  - in_ready is 0 from that edge on.
- Simultaneous events:
  - start with in_valid in IDLE or DONE: only start acts; in_ready is 0 in that cycle.
  - A write pending from the final accept completes even if start arrives in the same cycle. The counter clears after that write.
- Reset mid-session: any pending write is dropped; no imem_we is emitted after rst_n deasserts.
- in_ready is independent of in_valid combinationally (no valid-to-ready path).

## Structure

- Shared package riscv_isa_pkg holds:
  - the opcode constants (0110011, 0010011, 0000011, 0100011, 1100011);
  - the in_kind enum;
  - the LD/SD funct3 value 011.
- The Control decoder uses the same opcode constants.
- One combinational sub-module, instr_pack, computes the encoded word and the reject flag from the descriptor fields.
- The top level holds the FSM, the pointer/counter and the output registers.

## Test plan

- start; R rd=3 rs1=1 rs2=2 f3=0 f7=0 -> next cycle imem_we=1, addr 0, wdata 0x002081B3; word_count=1.
- Back-to-back IMM rd=5 rs1=0 imm=-1, LD rd=6 rs1=1 imm=8, SD rs1=1 rs2=2 imm=16, BEQ rs1=1 rs2=2 imm=-8 -> writes 0xFFF00293, 0x0080B303, 0x0020B823, 0xFE208CE3 at addrs 0–3 on consecutive cycles.
- IMM imm=2048, then BEQ imm=3, then kind 5 -> no imem_we for any; err=1; word_count unchanged; next legal word lands at the unchanged address.
- IMEM_AW=2, stream 5 valid R descriptors -> 4 writes at addrs 0–3; in_ready drops after the 4th accept; done=1; the 5th is held, not accepted.
- END accepted -> done=1, no write. start in DONE -> word_count=0, err=0, busy=1.
- Assert rst_n=0 on the cycle after an accept -> no write strobe appears; all outputs are 0 and the state is IDLE.
